// File: rtl/adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_rr_arbiter
// Brief    : Round-robin shares one carry-lookahead adder among NUM_REQ
//            requesters behind a single registered, id-tagged response.
// Revision : 1.0 - initial release
// ============================================================================

module fast_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N/4:0] w_c;
  assign w_c[0] = 1'b0;

  // Full lookahead inside each nibble, group carries chained between nibbles.
  for (genvar gi = 0; gi < N/4; gi++) begin : g_grp
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_cc;
    assign w_p     = a[gi*4 +: 4] ^ b[gi*4 +: 4];
    assign w_g     = a[gi*4 +: 4] & b[gi*4 +: 4];
    assign w_cc[0] = w_c[gi];
    assign w_cc[1] = w_g[0] | (w_p[0] & w_cc[0]);
    assign w_cc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_cc[0]);
    assign w_cc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & w_cc[0]);
    assign w_cc[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0]) | ((&w_p) & w_cc[0]);
    assign sum[gi*4 +: 4] = w_p ^ w_cc[3:0];
    assign w_c[gi+1]      = w_cc[4];
  end

  assign cout = w_c[N/4];
endmodule

module adder_rr_arbiter #(
  parameter int N       = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [N-1:0]         rsp_sum,
  output logic                 rsp_carry,
  output logic [CNT_W-1:0]     carry_count,
  output logic                 busy
);
  typedef enum logic [0:0] {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_rsp_id;
  logic [N-1:0]     r_rsp_sum;
  logic             r_rsp_carry;
  logic [CNT_W-1:0] r_cnt;

  logic [ID_W-1:0]  w_g;
  logic             w_any;
  logic             w_slot_free;
  logic             w_xfer;
  logic [N-1:0]     w_a, w_b, w_sum;
  logic             w_cout;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] p, input int k);
    logic [ID_W:0] s;
    s = {1'b0, p} + (ID_W+1)'(k);
    if (s >= (ID_W+1)'(NUM_REQ)) s = s - (ID_W+1)'(NUM_REQ);
    return s[ID_W-1:0];
  endfunction

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    w_g   = '0;
    w_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && req_valid[wrap_idx(r_ptr, k)]) begin
        w_g   = wrap_idx(r_ptr, k);
        w_any = 1'b1;
      end
    end
  end

  assign w_slot_free = (r_state == S_EMPTY) | rsp_ready;
  assign w_xfer      = w_any & w_slot_free & ~rst;

  always_comb begin
    req_ready = '0;
    if (w_xfer) req_ready[w_g] = 1'b1;
  end

  assign w_a = req_a[w_g*N +: N];
  assign w_b = req_b[w_g*N +: N];

  fast_adder #(.N(N)) u_adder (
    .a   (w_a),
    .b   (w_b),
    .sum (w_sum),
    .cout(w_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_xfer) w_state_nxt = S_FULL;
      S_FULL:  if (rsp_ready && !w_xfer) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_ptr       <= '0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_carry <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_ptr       <= (w_g == ID_W'(NUM_REQ-1)) ? '0 : w_g + 1'b1;
        r_rsp_id    <= w_g;
        r_rsp_sum   <= w_sum;
        r_rsp_carry <= w_cout;
        if (w_cout && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign rsp_valid   = (r_state == S_FULL);
  assign busy        = rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_sum     = r_rsp_sum;
  assign rsp_carry   = r_rsp_carry;
  assign carry_count = r_cnt;
endmodule

`default_nettype wire

// File: tb/tb_adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_rr_arbiter
// Brief    : Directed plus random stimulus against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adder_rr_arbiter;
  localparam int N = 8, NR = 4, IDW = 2, CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*N-1:0] req_a, req_b;
  logic [NR-1:0] req_ready;
  logic          rsp_valid, rsp_ready, rsp_carry, busy;
  logic [IDW-1:0] rsp_id;
  logic [N-1:0]  rsp_sum;
  logic [CW-1:0] carry_count;

  adder_rr_arbiter #(.N(N), .NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .carry_count(carry_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  // Model state: pending response and rotating priority pointer.
  int m_ptr = 0, m_id = 0, m_sum = 0, m_cnt = 0;
  bit m_valid = 0, m_carry = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++)
      if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready(input logic r, input logic [NR-1:0] v, input logic rdy);
    int g;
    g = winner(v);
    if (r || (m_valid && !rdy) || g < 0) return '0;
    return NR'(1) << g;
  endfunction

  // Called just after a falling edge: drive, check accept, clock, check response.
  task automatic run_cycle(input logic r, input logic [NR-1:0] v,
                           input logic [31:0] a, input logic [31:0] b, input logic rdy);
    logic [NR-1:0] er;
    int g, s;
    rst = r; req_valid = v; req_a = a; req_b = b; rsp_ready = rdy;
    #1;
    er = exp_ready(r, v, rdy);
    check("req_ready", 32'(req_ready), 32'(er));
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_id = 0; m_sum = 0; m_carry = 0; m_cnt = 0; m_ptr = 0;
    end else if (er != '0) begin
      g = winner(v);
      s = int'(a[g*N +: N]) + int'(b[g*N +: N]);
      m_sum = s % 256; m_carry = (s >= 256); m_id = g; m_valid = 1;
      if (m_carry && m_cnt < 3) m_cnt++;
      m_ptr = (g + 1) % NR;
    end else if (rdy) begin
      m_valid = 0;
    end
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_valid));
    check("rsp_id", 32'(rsp_id), m_id);
    check("rsp_sum", 32'(rsp_sum), m_sum);
    check("rsp_carry", 32'(rsp_carry), 32'(m_carry));
    check("carry_count", 32'(carry_count), m_cnt);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    @(negedge clk);
    run_cycle(1, 4'b0000, 0, 0, 1);
    check("reset_valid", 32'(rsp_valid), 0);

    // Single request from requester 0.
    run_cycle(0, 4'b0001, 32'h0000003C, 32'h00000005, 1);
    check("t1_sum", 32'(rsp_sum), 32'h41);

    // Requester 2 overflows repeatedly; counter saturates at 3.
    run_cycle(1, 4'b0000, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      run_cycle(0, 4'b0100, 32'h00FF0000, 32'h00010000, 1);
    check("t2_sat", 32'(carry_count), 3);

    // Full load rotation.
    run_cycle(1, 4'b0000, 0, 0, 1);
    for (int i = 0; i < 6; i++)
      run_cycle(0, 4'b1111, $urandom, $urandom, 1);
    check("t3_last_id", 32'(rsp_id), 1);

    // Backpressure with requesters 1 and 3 waiting.
    run_cycle(1, 4'b0000, 0, 0, 1);
    run_cycle(0, 4'b0001, 32'h11, 32'h22, 1);
    for (int i = 0; i < 3; i++)
      run_cycle(0, 4'b1010, 32'h40302010, 32'h01020304, 0);
    run_cycle(0, 4'b1010, 32'h40302010, 32'h01020304, 1);
    check("t4_id", 32'(rsp_id), 1);

    // Pointer holds across idle cycles.
    run_cycle(0, 4'b1000, 32'h7F000000, 32'h01000000, 1);
    for (int i = 0; i < 4; i++) run_cycle(0, 4'b0000, 0, 0, 1);
    run_cycle(0, 4'b0110, 32'h00050300, 32'h00060400, 1);
    check("t5_id", 32'(rsp_id), 1);

    // Reset while a response is stalled.
    run_cycle(0, 4'b0100, 32'h00800000, 32'h00800000, 0);
    run_cycle(0, 4'b0000, 0, 0, 0);
    run_cycle(1, 4'b1111, $urandom, $urandom, 0);
    run_cycle(0, 4'b1111, $urandom, $urandom, 1);
    check("t6_id", 32'(rsp_id), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      run_cycle(($urandom_range(0, 99) == 0), 4'($urandom), $urandom, $urandom,
                ($urandom_range(0, 9) < 7));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
Shares one fast_adder instance (N-bit carry-lookahead, no carry-in) between NUM_REQ independent requesters.
Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter grants one request per cycle. The sum and carry-out are returned through a single registered response channel tagged with the requester index. An internal saturating counter tracks accepted operations that produced a carry-out.

Parameters:
N, 32, operand/sum width; must be a multiple of 4 (fast_adder constraint), N >= 4
NUM_REQ, 4, number of requesters, 2..16
ID_W, $clog2(NUM_REQ), width of requester index
CNT_W, 16, width of carry-out event counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_a  in  NUM_REQ*N  operand a; requester i occupies bits [i*N +: N]
req_b  in  NUM_REQ*N  operand b; same packing as req_a
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
rsp_valid  out  1  response valid
rsp_ready  in  1  downstream accepts response
rsp_id  out  ID_W  index of the requester that owns the response
rsp_sum  out  N  a+b mod 2^N
rsp_carry  out  1  carry-out of a+b
carry_count  out  CNT_W  number of accepted operations with carry-out=1; saturates at all-ones
busy  out  1  equals rsp_valid (response register occupied)

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, carry_count=0.
  - RR pointer=0, so requester 0 has highest priority after reset.
  - Reset mid-operation discards any held response without handshake.
  - req_ready is 0 while rst=1.
- Slot-free condition: slot_free = ~rsp_valid | rsp_ready. This allows back-to-back operations, one per cycle, when downstream keeps rsp_ready=1.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, ascending, wrapping modulo NUM_REQ. The first asserted index is the winner g.
  - req_ready[g] = slot_free & ~rst; all other req_ready bits are 0.
  - If no req_valid is asserted, req_ready = 0.
- Handshake: a transfer occurs for requester g when req_valid[g] & req_ready[g] at a clock edge.
- On transfer:
  - The adder operands are muxed from requester g.
  - Next cycle: rsp_valid=1, rsp_id=g, rsp_sum=s, rsp_carry=c.
  - ptr <= (g+1) mod NUM_REQ.
- Latency: exactly 1 cycle from the accepting edge to rsp_valid high. The adder is combinational and is registered only at the response register.
- Response hold:
  - While rsp_valid=1 and rsp_ready=0, rsp_id, rsp_sum and rsp_carry hold stable and req_ready = 0.
  - On rsp_ready=1 with no new transfer, rsp_valid <= 0.
  - On rsp_ready=1 with a simultaneous transfer, the response register is overwritten with the new result and rsp_valid stays 1. No bubble, no loss.
- Pointer update: ptr changes only on a transfer. If there is no transfer, ptr holds, including while the response is stalled.
- Fairness: with all NUM_REQ requesters continuously valid and rsp_ready=1, grants rotate 0,1,...,NUM_REQ-1,0,... One grant per cycle.
- Request stability: requesters keep req_a/req_b stable while req_valid=1 and not yet accepted. The block samples operands only on the accepting edge.
- carry_count:
  - Increments by 1 at each accepting edge whose adder carry-out is 1.
  - Holds at 2^CNT_W-1 once reached (no wrap).
  - Cleared only by rst.
- Arithmetic: rsp_sum and rsp_carry equal the low N bits and bit N of the zero-extended a+b.
- Response register state machine:
  - EMPTY -> FULL on a transfer.
  - FULL -> EMPTY on rsp_ready with no transfer.
  - FULL -> FULL on stall, or on rsp_ready together with a transfer.
  - Any state -> EMPTY on rst.

Test Plan:
1. Reset then single request (N=8): req_valid=0001, a0=0x3C, b0=0x05. req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x41, rsp_carry=0; carry_count=0.
2. Carry and saturation (N=8, CNT_W=2): requester 2 sends 0xFF+0x01 five times. Each response is sum=0x00, carry=1, id=2. carry_count steps 1,2,3,3,3.
3. Round-robin under full load: all four requesters valid, rsp_ready=1. Accept order 0,1,2,3,0,1. rsp_valid stays 1 every cycle after the first, with no bubbles.
4. Backpressure: hold rsp_ready=0 for 3 cycles with a response pending and requesters 1 and 3 valid. req_ready=0 and the rsp_* fields are stable throughout. On rsp_ready=1, the next grant goes to the correct RR successor in the same cycle.
5. Pointer hold: grant requester 3 (ptr becomes 0), then idle 4 cycles, then assert requesters 1 and 2. Requester 1 is granted first.
6. Reset mid-operation: assert rst while rsp_valid=1 and rsp_ready=0. The next cycle shows rsp_valid=0, carry_count=0, req_ready=0 during rst, and requester 0 has priority afterwards.
